div_sched: RTL and testbench

//  Multi-cycle integer divide unit with its sequencing FSM. Serves RV32M DIV/DIVU/REM/REMU for the EX stage.

---
 rtl/div_sched.sv | 193 +++++++++++++++++++
 tb/tb_div_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_sched.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU) with IDLE/CALC/DONE sequencing FSM.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sched #(
  parameter int XLEN         = 32,
  parameter int BITS_PER_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [5:0]      rd_addr,
  input  logic            flush,
  input  logic            bus_stall,
  output logic            stall_ex,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [5:0]      rd_addr_out
);
  localparam int NCYC = XLEN / BITS_PER_CYC;
  localparam int CW   = $clog2(NCYC + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            is_rem_q, qneg_q, rneg_q;
  logic [5:0]      rd_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic            done_q, busy_q;
  logic [XLEN-1:0] result_q;
  logic [5:0]      rd_out_q;

  logic            sgn, s1_neg, s2_neg, div0, ovf, c_hit;
  logic [XLEN-1:0] a1, a2, sp_q, sp_r;
  logic [XLEN-1:0] r_w, q_w, fin_q, fin_r;
  logic [XLEN:0]   sh_w;

`ifdef DIV_RESULT_CACHE_EN
  logic            c_vld_q, c_sgn_q, sgn_q;
  logic [XLEN-1:0] c_s1_q, c_s2_q, c_q_q, c_r_q, s1_q, s2_q;
  assign c_hit = c_vld_q && (c_s1_q == src1) && (c_s2_q == src2) && (c_sgn_q == sgn);
`else
  assign c_hit = 1'b0;
`endif

  assign sgn    = ~op[0];
  assign s1_neg = sgn & src1[XLEN-1];
  assign s2_neg = sgn & src2[XLEN-1];
  assign a1     = s1_neg ? -src1 : src1;
  assign a2     = s2_neg ? -src2 : src2;
  assign div0   = (src2 == '0);
  assign ovf    = sgn && (src1 == MIN_NEG) && (&src2);

  // Combinational in the accept cycle so EX freezes before the first iteration edge.
  assign stall_ex = !flush && ((state_q == IDLE && start) || state_q == CALC);

  always_comb begin
    sp_q = '1;
    sp_r = src1;
    if (!div0 && ovf) begin
      sp_q = MIN_NEG;
      sp_r = '0;
    end
`ifdef DIV_RESULT_CACHE_EN
    if (!div0 && !ovf) begin
      sp_q = c_q_q;
      sp_r = c_r_q;
    end
`endif
  end

  // Restoring shift-subtract; the remainder stays below the divisor so XLEN bits suffice between steps.
  always_comb begin
    r_w  = rem_q;
    q_w  = quo_q;
    sh_w = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      sh_w = {r_w, q_w[XLEN-1]};
      q_w  = {q_w[XLEN-2:0], 1'b0};
      if (sh_w >= {1'b0, dvs_q}) begin
        sh_w   = sh_w - {1'b0, dvs_q};
        q_w[0] = 1'b1;
      end
      r_w = sh_w[XLEN-1:0];
    end
  end

  assign fin_q = qneg_q ? -q_w : q_w;
  assign fin_r = rneg_q ? -r_w : r_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rd_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
`ifdef DIV_RESULT_CACHE_EN
      c_vld_q  <= 1'b0;
      c_sgn_q  <= 1'b0;
      sgn_q    <= 1'b0;
      c_s1_q   <= '0;
      c_s2_q   <= '0;
      c_q_q    <= '0;
      c_r_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
`endif
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          is_rem_q <= op[1];
          qneg_q   <= s1_neg ^ s2_neg;
          rneg_q   <= s1_neg;
          rd_q     <= rd_addr;
          busy_q   <= 1'b1;
`ifdef DIV_RESULT_CACHE_EN
          s1_q  <= src1;
          s2_q  <= src2;
          sgn_q <= sgn;
`endif
          if (div0 || ovf || c_hit) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= op[1] ? sp_r : sp_q;
            rd_out_q <= rd_addr;
`ifdef DIV_RESULT_CACHE_EN
            c_vld_q <= 1'b1;
            c_s1_q  <= src1;
            c_s2_q  <= src2;
            c_sgn_q <= sgn;
            c_q_q   <= sp_q;
            c_r_q   <= sp_r;
`endif
          end else begin
            state_q <= CALC;
            cnt_q   <= CW'(NCYC);
            rem_q   <= '0;
            quo_q   <= a1;
            dvs_q   <= a2;
          end
        end
        CALC: begin
          rem_q <= r_w;
          quo_q <= q_w;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= is_rem_q ? fin_r : fin_q;
            rd_out_q <= rd_q;
`ifdef DIV_RESULT_CACHE_EN
            c_vld_q <= 1'b1;
            c_s1_q  <= s1_q;
            c_s2_q  <= s2_q;
            c_sgn_q <= sgn_q;
            c_q_q   <= fin_q;
            c_r_q   <= fin_r;
`endif
          end
        end
        DONE: if (!bus_stall) begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign rd_addr_out = rd_out_q;
endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed RV32M cases, randomized ops against an arithmetic model,
// flush, bus_stall hold, mid-operation reset and (with DIV_RESULT_CACHE_EN) result-cache hits.
module tb_div_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush, bus_stall;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic [5:0]  rd_addr;
  logic        stall_ex, busy, done;
  logic [31:0] result;
  logic [5:0]  rd_addr_out;

  int checks = 0;
  int errors = 0;

  // Model of the last completed operation key (cache builds only use it).
  logic        c_vld;
  logic [31:0] c_a, c_b;
  logic        c_sgn;

  div_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src1(src1), .src2(src2),
    .rd_addr(rd_addr), .flush(flush), .bus_stall(bus_stall), .stall_ex(stall_ex),
    .busy(busy), .done(done), .result(result), .rd_addr_out(rd_addr_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic hit;
    hit = 1'b0;
`ifdef DIV_RESULT_CACHE_EN
    hit = c_vld && c_a == a && c_b == b && c_sgn == ~o[0];
`endif
    if (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || hit) return 1;
    return 33;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] rd, input int bs, input string tag);
    int lat, n, stalls;
    logic [31:0] exp;
    exp = ref_res(o, a, b);
    lat = ref_lat(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; src1 = a; src2 = b; rd_addr = rd; bus_stall = (bs > 0);
    #1;
    stalls = stall_ex ? 1 : 0;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (stall_ex) stalls++;
      if (n >= 100) break;
    end
    checks++;
    if (n !== lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", tag, n, lat); end
    checks++;
    if (stalls !== lat) begin errors++; $display("FAIL %s stall_cycles: got %0d want %0d", tag, stalls, lat); end
    checks++;
    if (done !== 1'b1 || result !== exp) begin
      errors++; $display("FAIL %s result: done=%b got %h want %h", tag, done, result, exp);
    end
    checks++;
    if (rd_addr_out !== rd) begin errors++; $display("FAIL %s rd_addr_out: got %0d want %0d", tag, rd_addr_out, rd); end
    checks++;
    if (stall_ex !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s done_cycle: stall_ex=%b busy=%b want 0/1", tag, stall_ex, busy);
    end
    c_vld = 1'b1; c_a = a; c_b = b; c_sgn = ~o[0];
    for (int k = 2; k <= bs + 1; k++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || result !== exp || rd_addr_out !== rd) begin
        errors++; $display("FAIL %s hold_%0d: done=%b result=%h want 1/%h", tag, k, done, result, exp);
      end
    end
    start = 1'b0; bus_stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s to_idle: done=%b busy=%b want 0/0", tag, done, busy);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; bus_stall = 1'b0;
    op = 2'b00; src1 = '0; src2 = '0; rd_addr = '0;
    c_vld = 1'b0; c_a = '0; c_b = '0; c_sgn = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({stall_ex, busy, done, result, rd_addr_out} !== 41'd0) begin
      errors++; $display("FAIL reset_state: stall=%b busy=%b done=%b result=%h rd=%0d want all 0",
                         stall_ex, busy, done, result, rd_addr_out);
    end
  endtask

  task automatic test_directed();
    run_op(2'b01, 32'd100, 32'd7, 6'd5, 0, "divu_100_7");
    run_op(2'b10, -32'sd7, 32'd2, 6'd9, 0, "rem_m7_2");
    run_op(2'b00, -32'sd7, 32'd2, 6'd10, 0, "div_m7_2");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 6'd11, 0, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 6'd12, 0, "rem_ovf");
    run_op(2'b11, 32'd9, 32'd0, 6'd13, 0, "remu_div0");
    run_op(2'b01, 32'd9, 32'd0, 6'd14, 0, "divu_div0");
    run_op(2'b00, 32'hFFFF_FFF0, 32'd0, 6'd15, 0, "div_div0");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b, pa, pb;
    pa = 32'd1; pb = 32'd1;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 17));
        3: begin a = pa; b = pb; end
        4: b = -32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(o, a, b, 6'($urandom_range(0, 63)), 0, $sformatf("rand_%0d", i));
      pa = a; pb = b;
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    start = 1'b1; op = 2'b01; src1 = 32'd1000; src2 = 32'd3; rd_addr = 6'd7;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b0;
    #1;
    checks++;
    if (stall_ex !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b want 0", stall_ex); end
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_ex !== 1'b0) begin
      errors++; $display("FAIL flush_idle: busy=%b done=%b stall=%b want 0/0/0", busy, done, stall_ex);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done cycles want 0", seen); end
    run_op(2'b01, 32'd8, 32'd2, 6'd3, 0, "divu_after_flush");
    // flush wins over start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; src1 = 32'd77; src2 = 32'd5;
    #1;
    checks++;
    if (stall_ex !== 1'b0) begin errors++; $display("FAIL flush_prio_stall: got %b want 0", stall_ex); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_prio_busy: got %b want 0", busy); end
    start = 1'b0; flush = 1'b0;
  endtask

  task automatic test_bus_stall();
    run_op(2'b00, -32'sd1000, 32'd7, 6'd21, 3, "bus_stall_norm");
    run_op(2'b11, 32'd55, 32'd0, 6'd22, 2, "bus_stall_spec");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = 2'b01; src1 = 32'd12345; src2 = 32'd7; rd_addr = 6'd33;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0; start = 1'b0;
    #1;
    checks++;
    if ({stall_ex, busy, done, result, rd_addr_out} !== 41'd0) begin
      errors++; $display("FAIL reset_mid: stall=%b busy=%b done=%b result=%h rd=%0d want all 0",
                         stall_ex, busy, done, result, rd_addr_out);
    end
    c_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cache_pair();
    run_op(2'b00, 32'd50, 32'd6, 6'd1, 0, "div_50_6");
    run_op(2'b10, 32'd50, 32'd6, 6'd2, 0, "rem_50_6");
    run_op(2'b11, 32'd50, 32'd6, 6'd4, 0, "remu_50_6");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_bus_stall();
    test_reset_mid();
    test_cache_pair();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
